// File: rtl/player_jump_ctrl_pkg.sv
// Shared types and tuning defaults for the player jump controller, so the
// renderer and collision logic agree on the arc parameters.
package jump_pkg;

    typedef enum logic [1:0] {
        JS_GROUND  = 2'd0,
        JS_RISE    = 2'd1,
        JS_DESCEND = 2'd2,
        JS_FALLOUT = 2'd3
    } jump_state_t;

    localparam int DEF_HEIGHT_W  = 10;
    localparam int DEF_JUMP_VEL  = 14;
    localparam int DEF_GRAVITY   = 1;
    localparam int DEF_MAX_JUMPS = 2;
    localparam int DEF_FALL_STEP = 20;

    // Width of a counter able to hold 0..max_jumps.
    function automatic int jumps_w(input int max_jumps);
        return $clog2(max_jumps + 32'sd1);
    endfunction

endpackage

// File: rtl/player_jump_ctrl_if.sv
// Control and status bundle between the game logic and the jump controller.
interface player_jump_ctrl_if
    import jump_pkg::*;
#(
    parameter int HEIGHT_W = DEF_HEIGHT_W,
    parameter int JL_W     = 2
) ();
    logic                tick;
    logic                jump;
    logic                fall_en;
    logic [HEIGHT_W-1:0] height;
    logic                airborne;
    logic                landed;
    logic [JL_W-1:0]     jumps_left;

    modport master (
        output tick, jump, fall_en,
        input  height, airborne, landed, jumps_left
    );

    modport slave (
        input  tick, jump, fall_en,
        output height, airborne, landed, jumps_left
    );
endinterface

// File: rtl/player_jump_ctrl_integrator.sv
// Signed height/velocity datapath: launch load, gravity step with top/bottom
// saturation, landing clear and fall-out descent, strobed by the jump FSM.
module jump_integrator #(
    parameter int HEIGHT_W  = 10,
    parameter int JUMP_VEL  = 14,
    parameter int GRAVITY   = 1,
    parameter int FALL_STEP = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fall,
    input  logic                clear,
    input  logic                load,
    input  logic                step,
    output logic [HEIGHT_W-1:0] height,
    output logic                land_hit,
    output logic                step_vel_neg
);
    localparam int VW = HEIGHT_W + 1;
    localparam int SW = HEIGHT_W + 2;
    localparam logic signed [SW-1:0] H_MAX  = SW'((32'd1 << HEIGHT_W) - 32'd1);
    localparam logic signed [SW-1:0] JV_S   = SW'(JUMP_VEL);
    localparam logic signed [SW-1:0] FS_S   = SW'(FALL_STEP);
    localparam logic signed [VW-1:0] G_V    = VW'(GRAVITY);
    localparam logic signed [VW-1:0] LOAD_V = VW'(JUMP_VEL - GRAVITY);

    logic [HEIGHT_W-1:0]   height_r;
    logic signed [VW-1:0]  vel_r;
    logic signed [SW-1:0]  sum_s;
    logic signed [SW-1:0]  launch_s;
    logic signed [SW-1:0]  fall_s;
    logic signed [VW-1:0]  vel_next_s;
    logic                  top_sat_s;

    // Candidate next heights; one guard bit above HEIGHT_W plus a sign bit.
    always_comb begin
        sum_s        = $signed({2'b00, height_r}) + $signed({vel_r[VW-1], vel_r});
        launch_s     = $signed({2'b00, height_r}) + JV_S;
        fall_s       = $signed({2'b00, height_r}) - FS_S;
        vel_next_s   = vel_r - G_V;
        top_sat_s    = (sum_s > H_MAX);
        land_hit     = sum_s[SW-1] || (sum_s == {SW{1'b0}});
        step_vel_neg = !top_sat_s && vel_next_s[VW-1];
    end

    // Height/velocity registers; strobes are mutually exclusive from the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            height_r <= {HEIGHT_W{1'b0}};
            vel_r    <= {VW{1'b0}};
        end else if (fall) begin
            height_r <= fall_s[SW-1] ? {HEIGHT_W{1'b0}} : fall_s[HEIGHT_W-1:0];
            vel_r    <= {VW{1'b0}};
        end else if (clear) begin
            height_r <= {HEIGHT_W{1'b0}};
            vel_r    <= {VW{1'b0}};
        end else if (load) begin
            height_r <= (launch_s > H_MAX) ? H_MAX[HEIGHT_W-1:0] : launch_s[HEIGHT_W-1:0];
            vel_r    <= LOAD_V;
        end else if (step) begin
            if (top_sat_s) begin
                // Clamped at the ceiling: kill the velocity so the arc turns over.
                height_r <= H_MAX[HEIGHT_W-1:0];
                vel_r    <= {VW{1'b0}};
            end else begin
                height_r <= sum_s[SW-1] ? {HEIGHT_W{1'b0}} : sum_s[HEIGHT_W-1:0];
                vel_r    <= vel_next_s;
            end
        end
    end

    assign height = height_r;
endmodule

// File: rtl/player_jump_ctrl.sv
// Player jump controller: tick-driven parabolic jump with multi-jump, landing
// pulse and a terminal fall-out mode used by the win animation.
module player_jump_ctrl
    import jump_pkg::*;
#(
    parameter int HEIGHT_W  = DEF_HEIGHT_W,
    parameter int JUMP_VEL  = DEF_JUMP_VEL,
    parameter int GRAVITY   = DEF_GRAVITY,
    parameter int MAX_JUMPS = DEF_MAX_JUMPS,
    parameter int FALL_STEP = DEF_FALL_STEP
) (
    input logic               clk,
    input logic               reset,
    player_jump_ctrl_if.slave bus
);
    localparam int JL_W = jumps_w(MAX_JUMPS);
    localparam logic [JL_W-1:0] JL_MAX = JL_W'(MAX_JUMPS);
    localparam logic [JL_W-1:0] JL_ONE = JL_W'(32'd1);

    jump_state_t         state_r;
    logic                pending_r;
    logic [JL_W-1:0]     jumps_left_r;
    logic                landed_r;
    logic                airborne_r;
    logic                jump_now_s;
    logic                fall_s;
    logic                clear_s;
    logic                load_s;
    logic                step_s;
    logic                land_hit_s;
    logic                step_vel_neg_s;
    logic [HEIGHT_W-1:0] height_s;

    // Tick action decode; fall-out beats landing, landing beats launch.
    always_comb begin
        jump_now_s = pending_r | bus.jump;
        fall_s     = 1'b0;
        clear_s    = 1'b0;
        load_s     = 1'b0;
        step_s     = 1'b0;
        if (bus.tick) begin
            if (bus.fall_en || state_r == JS_FALLOUT) begin
                fall_s = 1'b1;
            end else if (state_r == JS_DESCEND && land_hit_s) begin
                clear_s = 1'b1;
            end else if (jump_now_s && jumps_left_r != {JL_W{1'b0}}) begin
                load_s = 1'b1;
            end else if (state_r == JS_RISE || state_r == JS_DESCEND) begin
                step_s = 1'b1;
            end else begin
                step_s = 1'b0;
            end
        end else begin
            fall_s = 1'b0;
        end
    end

    // Jump state machine with registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= JS_GROUND;
            pending_r    <= 1'b0;
            jumps_left_r <= JL_MAX;
            landed_r     <= 1'b0;
            airborne_r   <= 1'b0;
        end else begin
            landed_r <= 1'b0;
            if (fall_s) begin
                state_r    <= JS_FALLOUT;
                pending_r  <= 1'b0;
                airborne_r <= 1'b0;
            end else if (clear_s) begin
                // A press arriving around touchdown survives to launch next tick.
                state_r      <= JS_GROUND;
                pending_r    <= jump_now_s;
                jumps_left_r <= JL_MAX;
                landed_r     <= 1'b1;
                airborne_r   <= 1'b0;
            end else if (load_s) begin
                state_r      <= JS_RISE;
                pending_r    <= 1'b0;
                jumps_left_r <= jumps_left_r - JL_ONE;
                airborne_r   <= 1'b1;
            end else if (bus.tick) begin
                pending_r <= 1'b0;
                if (step_s && state_r == JS_RISE && step_vel_neg_s) begin
                    state_r <= JS_DESCEND;
                end
            end else if (bus.jump && state_r != JS_FALLOUT) begin
                pending_r <= 1'b1;
            end
        end
    end

    jump_integrator #(
        .HEIGHT_W  (HEIGHT_W),
        .JUMP_VEL  (JUMP_VEL),
        .GRAVITY   (GRAVITY),
        .FALL_STEP (FALL_STEP)
    ) u_integrator (
        .clk          (clk),
        .reset        (reset),
        .fall         (fall_s),
        .clear        (clear_s),
        .load         (load_s),
        .step         (step_s),
        .height       (height_s),
        .land_hit     (land_hit_s),
        .step_vel_neg (step_vel_neg_s)
    );

    assign bus.height     = height_s;
    assign bus.airborne   = airborne_r;
    assign bus.landed     = landed_r;
    assign bus.jumps_left = jumps_left_r;
endmodule

// File: tb/tb_player_jump_ctrl.sv
// Scoreboard bench for player_jump_ctrl: default build plus a narrow
// HEIGHT_W=6 / JUMP_VEL=30 build driven by the same stimulus.
module tb_player_jump_ctrl;
    localparam int M_GND  = 0;
    localparam int M_RISE = 1;
    localparam int M_DESC = 2;
    localparam int M_FALL = 3;
    localparam int G      = 1;
    localparam int FS     = 20;
    localparam int MAXJ   = 2;
    localparam int A_HW   = 10;
    localparam int A_JV   = 14;
    localparam int B_HW   = 6;
    localparam int B_JV   = 30;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic jump;
    logic fall_en;

    always #5 clk = ~clk;

    player_jump_ctrl_if #(.HEIGHT_W(A_HW), .JL_W(2)) ifa ();
    player_jump_ctrl_if #(.HEIGHT_W(B_HW), .JL_W(2)) ifb ();

    assign ifa.tick    = tick;
    assign ifa.jump    = jump;
    assign ifa.fall_en = fall_en;
    assign ifb.tick    = tick;
    assign ifb.jump    = jump;
    assign ifb.fall_en = fall_en;

    player_jump_ctrl #(.HEIGHT_W(A_HW), .JUMP_VEL(A_JV), .GRAVITY(G),
                       .MAX_JUMPS(MAXJ), .FALL_STEP(FS))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));

    player_jump_ctrl #(.HEIGHT_W(B_HW), .JUMP_VEL(B_JV), .GRAVITY(G),
                       .MAX_JUMPS(MAXJ), .FALL_STEP(FS))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct packed { int mode; int h; int v; int jl; bit pend; } mdl_t;
    typedef struct packed { int h; bit air; bit land; int jl; } exp_t;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   cap_ah, cap_ajl, cap_bh;
    bit   cap_aland, cap_aair;
    int   arc_h[30];
    int   arc_jl[30];
    bit   arc_land[30];
    int   arc_bh[30];
    int   fall_exp[7];
    int   guard;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
    endtask

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.mode = M_GND; m.h = 0; m.v = 0; m.jl = MAXJ; m.pend = 1'b0;
        return m;
    endfunction

    // Behavioural reference: one clock of the jump rules in plain integers.
    function automatic void mdl_step(inout mdl_t m, input bit t, input bit j, input bit f,
                                     input int hmax, input int jv, output bit land);
        bit want;
        int s;
        land = 1'b0;
        want = m.pend || j;
        if (!t) begin
            if (j && m.mode != M_FALL) m.pend = 1'b1;
        end else if (f || m.mode == M_FALL) begin
            m.mode = M_FALL;
            m.h    = (m.h > FS) ? m.h - FS : 0;
            m.v    = 0;
            m.pend = 1'b0;
        end else if (m.mode == M_DESC && m.h + m.v <= 0) begin
            m.mode = M_GND; m.h = 0; m.v = 0; m.jl = MAXJ;
            m.pend = want;
            land   = 1'b1;
        end else if (want && m.jl > 0) begin
            m.h    = (m.h + jv > hmax) ? hmax : m.h + jv;
            m.v    = jv - G;
            m.jl   = m.jl - 1;
            m.mode = M_RISE;
            m.pend = 1'b0;
        end else begin
            m.pend = 1'b0;
            if (m.mode == M_RISE || m.mode == M_DESC) begin
                s = m.h + m.v;
                if (s > hmax) begin
                    m.h = hmax; m.v = 0;
                end else begin
                    m.h = (s < 0) ? 0 : s;
                    m.v = m.v - G;
                end
                if (m.mode == M_RISE && m.v < 0) m.mode = M_DESC;
            end
        end
    endfunction

    function automatic exp_t mdl_view(input mdl_t m, input bit land);
        exp_t e;
        e.h    = m.h;
        e.air  = (m.mode == M_RISE || m.mode == M_DESC);
        e.land = land;
        e.jl   = m.jl;
        return e;
    endfunction

    // Drive one clock of stimulus and queue what both builds must show after it.
    task automatic cycle(input bit t, input bit j, input bit f);
        bit la, lb;
        @(negedge clk);
        tick = t; jump = j; fall_en = f;
        mdl_step(ma, t, j, f, (1 << A_HW) - 1, A_JV, la);
        mdl_step(mb, t, j, f, (1 << B_HW) - 1, B_JV, lb);
        qa.push_back(mdl_view(ma, la));
        qb.push_back(mdl_view(mb, lb));
        mon_en = 1'b1;
    endtask

    task automatic do_tick(input bit j, input bit f);
        cycle(1'b1, j, f);
        @(posedge clk);
        #2;
        cap_ah    = int'(ifa.height);
        cap_ajl   = int'(ifa.jumps_left);
        cap_aland = ifa.landed;
        cap_aair  = ifa.airborne;
        cap_bh    = int'(ifb.height);
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_idle(input bit j);
        cycle(1'b0, j, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        qa.delete();
        qb.delete();
        reset = 1'b1; tick = 1'b0; jump = 1'b0; fall_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.height", int'(ifa.height), 0);
        chk("rst.airborne", int'(ifa.airborne), 0);
        chk("rst.landed", int'(ifa.landed), 0);
        chk("rst.jumps_left", int'(ifa.jumps_left), MAXJ);
        chk("rst.b_height", int'(ifb.height), 0);
        reset = 1'b0;
        ma = mdl_init();
        mb = mdl_init();
    endtask

    // Monitor: every clock the outputs are live, pop and compare both builds.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (qa.size() == 0) begin
                    chk("a.queue_empty", 0, 1);
                end else begin
                    e = qa.pop_front();
                    chk("a.height", int'(ifa.height), e.h);
                    chk("a.airborne", int'(ifa.airborne), int'(e.air));
                    chk("a.landed", int'(ifa.landed), int'(e.land));
                    chk("a.jumps_left", int'(ifa.jumps_left), e.jl);
                end
                if (qb.size() == 0) begin
                    chk("b.queue_empty", 0, 1);
                end else begin
                    e = qb.pop_front();
                    chk("b.height", int'(ifb.height), e.h);
                    chk("b.airborne", int'(ifb.airborne), int'(e.air));
                    chk("b.landed", int'(ifb.landed), int'(e.land));
                    chk("b.jumps_left", int'(ifb.jumps_left), e.jl);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tick = 1'b0; jump = 1'b0; fall_en = 1'b0;
        ma = mdl_init();
        mb = mdl_init();
        do_reset();

        // Idle ticks keep the player on the ground.
        repeat (10) do_tick(1'b0, 1'b0);
        chk("idle.height", cap_ah, 0);
        chk("idle.jumps_left", cap_ajl, 2);
        chk("idle.airborne", int'(cap_aair), 0);

        // Single jump: full default arc.
        for (int k = 1; k <= 29; k++) begin
            do_tick(k == 1, 1'b0);
            arc_h[k]    = cap_ah;
            arc_jl[k]   = cap_ajl;
            arc_land[k] = cap_aland;
            arc_bh[k]   = cap_bh;
        end
        chk("arc.t1", arc_h[1], 14);
        chk("arc.t2", arc_h[2], 27);
        chk("arc.t14_peak", arc_h[14], 105);
        chk("arc.t15_hold", arc_h[15], 105);
        chk("arc.t28", arc_h[28], 14);
        chk("arc.t29_ground", arc_h[29], 0);
        chk("arc.t28_landed", int'(arc_land[28]), 0);
        chk("arc.t29_landed", int'(arc_land[29]), 1);
        chk("arc.t1_jl", arc_jl[1], 1);
        chk("arc.t29_jl", arc_jl[29], 2);
        chk("narrow.t2", arc_bh[2], 59);
        chk("narrow.t3_sat", arc_bh[3], 63);
        chk("narrow.t4_hold", arc_bh[4], 63);

        // Double jump, then an ignored third press.
        do_tick(1'b1, 1'b0);
        repeat (4) do_tick(1'b0, 1'b0);
        chk("dbl.t5", cap_ah, 60);
        do_idle(1'b1);
        do_tick(1'b0, 1'b0);
        chk("dbl.t6", cap_ah, 74);
        chk("dbl.t6_jl", cap_ajl, 0);
        do_tick(1'b0, 1'b0);
        chk("dbl.t7", cap_ah, 87);
        do_idle(1'b1);
        do_tick(1'b0, 1'b0);
        chk("dbl.t8_ignored", cap_ah, 99);

        // Press one cycle before the landing tick.
        guard = 0;
        while (!(ma.mode == M_DESC && ma.h + ma.v <= 0) && guard < 300) begin
            do_tick(1'b0, 1'b0);
            guard++;
        end
        chk("land.reached", int'(guard < 300), 1);
        do_idle(1'b1);
        do_tick(1'b0, 1'b0);
        chk("land.height", cap_ah, 0);
        chk("land.pulse", int'(cap_aland), 1);
        do_tick(1'b0, 1'b0);
        chk("land.relaunch", cap_ah, 14);
        chk("land.relaunch_jl", cap_ajl, 1);

        // Fall-out from the peak.
        guard = 0;
        while (ma.mode != M_GND && guard < 300) begin
            do_tick(1'b0, 1'b0);
            guard++;
        end
        chk("fall.grounded", int'(guard < 300), 1);
        do_tick(1'b1, 1'b0);
        repeat (13) do_tick(1'b0, 1'b0);
        chk("fall.peak", cap_ah, 105);
        fall_exp = '{85, 65, 45, 25, 5, 0, 0};
        for (int i = 0; i < 7; i++) begin
            do_tick(1'b0, 1'b1);
            chk("fall.height", cap_ah, fall_exp[i]);
        end
        chk("fall.airborne", int'(cap_aair), 0);
        do_idle(1'b1);
        do_tick(1'b1, 1'b0);
        chk("fall.terminal_height", cap_ah, 0);
        chk("fall.terminal_airborne", int'(cap_aair), 0);

        // Asynchronous reset mid-air with a press pending.
        do_reset();
        do_tick(1'b1, 1'b0);
        repeat (4) do_tick(1'b0, 1'b0);
        chk("areset.pre", cap_ah, 60);
        cycle(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        reset = 1'b1; tick = 1'b0; jump = 1'b0;
        #1;
        chk("areset.height", int'(ifa.height), 0);
        chk("areset.airborne", int'(ifa.airborne), 0);
        chk("areset.jumps_left", int'(ifa.jumps_left), 2);
        @(negedge clk);
        reset = 1'b0;
        ma = mdl_init();
        mb = mdl_init();
        do_tick(1'b0, 1'b0);
        chk("areset.pending_lost", cap_ah, 0);

        // Randomized rounds, fall-out only late in each round.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                cycle($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                      (c >= 120) && ($urandom_range(0, 9) == 0));
            end
        end
        @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
